// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : Oversampling 8N1 UART receiver with a one-cycle valid strobe.
//               Define UART_RX_PARITY_EN to receive 8E1 frames and add the
//               parity_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int SYS_CLK_RATE = 160,
    parameter int BAUD_RATE    = 1,
    parameter int OVERSAMPLE   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_reg,
    output logic       rx_valid,
    output logic       rx_busy,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);

    localparam int c_DIV   = SYS_CLK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_SC_W  = $clog2(OVERSAMPLE);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_SC_W-1:0]  c_SC_MID   = c_SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SC_W-1:0]  c_SC_LAST  = c_SC_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_BREAK  = 3'd4
    } state_t;

    logic               sync1_q, sync2_q, prev_q, armed_q, armed_d;
    logic [1:0]         fill_q, fill_d;
    logic [c_DIV_W-1:0] div_q, div_d;
    logic [c_SC_W-1:0]  sc_q, sc_d;
    logic [2:0]         bc_q, bc_d;
    logic [7:0]         shift_q, shift_d, rx_reg_q, rx_reg_d;
    logic               valid_q, valid_d, busy_q, busy_d, ferr_q, ferr_d;
    state_t             state_q, state_d;
    logic               rxs, tick, sample, start_det;
`ifdef UART_RX_PARITY_EN
    logic               perr_q, perr_d, par_bad_q, par_bad_d;
`endif

    always_comb begin
        rxs       = sync2_q;
        tick      = (div_q == c_DIV_LAST);
        sample    = tick && (sc_q == ((state_q == ST_START) ? c_SC_MID : c_SC_LAST));
        // Start is ignored until the synchronizer has shown a real idle-high
        // line since reset, so a line held low through reset is not a start.
        start_det = armed_q & prev_q & ~rxs;
        fill_d    = {fill_q[0], 1'b1};
        armed_d   = armed_q | (fill_q[1] & rxs);
        div_d     = tick ? '0 : div_q + 1'b1;
        sc_d      = sc_q;
        if (tick) begin
            sc_d = sample ? '0 : sc_q + 1'b1;
        end
        state_d   = state_q;
        bc_d      = bc_q;
        shift_d   = shift_q;
        rx_reg_d  = rx_reg_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    state_d = ST_START;
                    div_d   = '0;
                    sc_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (sample) begin
                    if (!rxs) begin
                        state_d = ST_DATA;
                        bc_d    = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shift_d = {rxs, shift_q[7:1]};
                    bc_d    = bc_q + 3'd1;
                    if (bc_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample) begin
                    par_bad_d = (^shift_q) ^ rxs;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (sample) begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d  = 1'b1;
                            rx_reg_d = shift_q;
                        end
`else
                        valid_d  = 1'b1;
                        rx_reg_d = shift_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
            div_q     <= '0;
            sc_q      <= '0;
            bc_q      <= 3'd0;
            shift_q   <= 8'h00;
            rx_reg_q  <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
            state_q   <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            prev_q    <= rxs;
            fill_q    <= fill_d;
            armed_q   <= armed_d;
            div_q     <= div_d;
            sc_q      <= sc_d;
            bc_q      <= bc_d;
            shift_q   <= shift_d;
            rx_reg_q  <= rx_reg_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            ferr_q    <= ferr_d;
            state_q   <= state_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign rx_reg    = rx_reg_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = busy_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
`default_nettype wire
